// File: rtl/alu_bit_serial_ctrl_if.sv
// alu_bit_serial_ctrl_if
// Request/response bundle between the issue stage, the bit-serial ALU
// controller and the writeback consumer.
//   in_valid / in_ready   : request handshake
//   in_a, in_b, in_op     : operands and ALUOp of the request
//   out_valid / out_ready : result handshake
//   out_result            : assembled WIDTH-bit result
//   out_zero, out_carry,
//   out_ovf, out_illegal  : result flags
// modport master : issue/consumer side (drives requests, accepts results)
// modport slave  : controller side
interface alu_bit_serial_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic             out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry,
               out_ovf, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry,
               out_ovf, out_illegal
    );
endinterface

// File: rtl/alu_bit_serial_ctrl.sv
// alu_bit_serial_ctrl
// Drives one external 1-bit ALU slice for WIDTH cycles, LSB first, to carry
// out a full WIDTH-bit AND/OR/ADD/SUB/NOR. The slice does any operand
// inversion itself; the controller only sequences bits and threads the carry.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : request in / result out handshake bundle
//   slice_a/b      : current operand bits to the slice (0 outside RUN)
//   slice_cin      : carry into the slice (SUB injects 1 at bit 0)
//   slice_op       : latched ALUOp to the slice (0 outside RUN)
//   slice_res/cout : combinational result and carry back from the slice
module alu_bit_serial_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_bit_serial_ctrl_if.slave   bus,
    output logic                   slice_a,
    output logic                   slice_b,
    output logic                   slice_cin,
    output logic [3:0]             slice_op,
    input  logic                   slice_res,
    input  logic                   slice_cout
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic [3:0]       op_reg;
    logic [IW-1:0]    idx;
    logic             carry_reg;
    logic             carry_q, ovf_q, zero_q, illegal_q;

    logic             in_legal;
    logic             op_arith;
    logic             last_bit;
    logic [WIDTH-1:0] res_final;

    // Only the five supported ALUOps start a serial run; anything else
    // short-circuits straight to DONE with the illegal flag set.
    always_comb begin
        in_legal = 1'b0;
        case (bus.in_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: in_legal = 1'b1;
            default:                               in_legal = 1'b0;
        endcase
    end

    assign op_arith = (op_reg == OP_ADD) || (op_reg == OP_SUB);
    assign last_bit = (idx == LAST_IDX);

    // The result register still lacks the MSB on the final edge, so the
    // zero flag is taken from the result with the incoming bit merged in.
    always_comb begin
        res_final      = res_reg;
        res_final[idx] = slice_res;
    end

    // Next-state logic and slice drive; slice pins are parked at 0 unless a
    // run is in progress.
    always_comb begin
        state_d   = state_q;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 4'b0000;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = in_legal ? RUN : DONE;
                end
            end
            RUN: begin
                slice_a   = a_reg[idx];
                slice_b   = b_reg[idx];
                slice_cin = (idx == '0) ? (op_reg == OP_SUB) : carry_reg;
                slice_op  = op_reg;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operands are latched only on acceptance in IDLE, result bits
    // fill in one per RUN edge, and the flags settle on entry to DONE so they
    // stay frozen through any amount of output backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            op_reg    <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.in_a;
                        b_reg     <= bus.in_b;
                        op_reg    <= bus.in_op;
                        res_reg   <= '0;
                        idx       <= '0;
                        carry_reg <= 1'b0;
                        illegal_q <= !in_legal;
                        if (!in_legal) begin
                            carry_q <= 1'b0;
                            ovf_q   <= 1'b0;
                            zero_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    res_reg[idx] <= slice_res;
                    carry_reg    <= slice_cout;
                    idx          <= idx + IW'(1);
                    if (last_bit) begin
                        idx     <= '0;
                        carry_q <= op_arith & slice_cout;
                        ovf_q   <= op_arith & (slice_cin ^ slice_cout);
                        zero_q  <= ~|res_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_result  = res_reg;
    assign bus.out_zero    = zero_q;
    assign bus.out_carry   = carry_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_bit_serial_ctrl.sv
// tb_alu_bit_serial_ctrl
// Drives the bit-serial ALU controller (WIDTH=8) with an ideal 1-bit slice
// attached and compares results against a plain-arithmetic reference model.
module tb_alu_bit_serial_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slice_a, slice_b, slice_cin, slice_res, slice_cout;
    logic [3:0] slice_op;

    always #5 clk = ~clk;

    alu_bit_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_bit_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_op   (slice_op),
        .slice_res  (slice_res),
        .slice_cout (slice_cout)
    );

    // Ideal 1-bit slice: op[3] inverts A, op[2] inverts B, op[1:0] selects
    // AND / OR / full-adder sum.
    logic sa_eff, sb_eff;
    assign sa_eff     = slice_a ^ slice_op[3];
    assign sb_eff     = slice_b ^ slice_op[2];
    assign slice_cout = (sa_eff & sb_eff) | (sa_eff & slice_cin) | (sb_eff & slice_cin);
    always_comb begin
        slice_res = 1'b0;
        case (slice_op[1:0])
            2'b00:   slice_res = sa_eff & sb_eff;
            2'b01:   slice_res = sa_eff | sb_eff;
            2'b10:   slice_res = sa_eff ^ sb_eff ^ slice_cin;
            default: slice_res = 1'b0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    logic [W-1:0] cin_trace, a_trace, b_trace;
    logic [3:0]   op_trace0;

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};
    endfunction

    // Reference model from plain integer arithmetic.
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [3:0] op, output logic [W-1:0] r,
                                      output logic [3:0] flags);
        logic [W:0] wide;
        int         sa, sb, s;
        logic       c, v, z, ill;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[W-1:0];
                c = wide[W];
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            4'b0110: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            default: ill = 1'b1;
        endcase
        z = (r == '0);
        flags = {z, c, v, ill};
    endfunction

    // Carry seen entering each bit position when the slice runs the op.
    function automatic logic [W-1:0] exp_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op);
        logic [W-1:0] aa, bb, sum;
        aa  = op[3] ? ~a : a;
        bb  = op[2] ? ~b : b;
        sum = aa + bb + {{(W-1){1'b0}}, (op == 4'b0110)};
        return sum ^ aa ^ bb;
    endfunction

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] op, output bit ok);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, recording slice activity per bit and scrambling
    // the request inputs to show they are ignored outside IDLE.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        cin_trace = '0; a_trace = '0; b_trace = '0; op_trace0 = '0;
        while (!bus.out_valid && lat < 100) begin
            if (lat < W) begin
                cin_trace[lat] = slice_cin;
                a_trace[lat]   = slice_a;
                b_trace[lat]   = slice_b;
            end
            if (lat == 0) op_trace0 = slice_op;
            bus.in_a  = W'($urandom);
            bus.in_b  = W'($urandom);
            bus.in_op = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        ok = bus.out_valid;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.in_op = 4'b0010;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hs got ready=%b valid=%b exp ready=1 valid=0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if ({bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out got res=%h flags=%b%b%b%b exp all 0", bus.out_result,
                     bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal);
        end
        checks++;
        if ({slice_a, slice_b, slice_cin, slice_op} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_slice got %b exp 0", {slice_a, slice_b, slice_cin, slice_op});
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{8'h7F, 8'h05, 8'hF0, 8'hCC, 8'h35};
        logic [W-1:0] tb[5] = '{8'h01, 8'h05, 8'h0F, 8'hAA, 8'h48};
        logic [3:0]   to[5] = '{4'b0010, 4'b0110, 4'b1100, 4'b0000, 4'b0001};
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           lat;
        bit           ok;
        for (int k = 0; k < 5; k++) begin
            ref_model(ta[k], tb[k], to[k], er, ef);
            apply_stimulus(ta[k], tb[k], to[k], ok);
            if (ok) wait_done(lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL dir_timeout op=%b got no out_valid exp out_valid", to[k]);
                continue;
            end
            checks++;
            if (lat !== W) begin
                errors++;
                $display("[TB] FAIL dir_latency op=%b got %0d exp %0d", to[k], lat, W);
            end
            checks++;
            if (bus.out_result !== er) begin
                errors++;
                $display("[TB] FAIL dir_result op=%b got %h exp %h", to[k], bus.out_result, er);
            end
            checks++;
            if ({bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== ef) begin
                errors++;
                $display("[TB] FAIL dir_flags op=%b got %b exp %b", to[k],
                         {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal}, ef);
            end
            checks++;
            if (a_trace !== ta[k] || b_trace !== tb[k] || op_trace0 !== to[k]) begin
                errors++;
                $display("[TB] FAIL dir_slice_ops got a=%h b=%h op=%b exp a=%h b=%h op=%b",
                         a_trace, b_trace, op_trace0, ta[k], tb[k], to[k]);
            end
            checks++;
            if (cin_trace !== exp_cin(ta[k], tb[k], to[k])) begin
                errors++;
                $display("[TB] FAIL dir_cin op=%b got %b exp %b", to[k], cin_trace,
                         exp_cin(ta[k], tb[k], to[k]));
            end
            checks++;
            if ({slice_a, slice_b, slice_cin, slice_op} !== 7'd0) begin
                errors++;
                $display("[TB] FAIL dir_slice_idle got %b exp 0", {slice_a, slice_b, slice_cin, slice_op});
            end
            release_out();
        end
    endtask

    task automatic test_illegal();
        logic [3:0] iops[3] = '{4'b0011, 4'b0111, 4'b1111};
        int         lat;
        bit         ok;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(W'($urandom) | 8'h01, W'($urandom), iops[k], ok);
            if (ok) wait_done(lat, ok);
            checks++;
            if (!ok || lat !== 0) begin
                errors++;
                $display("[TB] FAIL ill_latency op=%b got %0d exp 0", iops[k], lat);
            end
            checks++;
            if (bus.out_result !== '0 ||
                {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== 4'b1001) begin
                errors++;
                $display("[TB] FAIL ill_out op=%b got res=%h flags=%b exp res=00 flags=1001", iops[k],
                         bus.out_result, {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal});
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, er1, er2;
        logic [3:0]   ef1, ef2;
        int           lat;
        bit           ok;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        ref_model(a1, b1, 4'b0010, er1, ef1);
        ref_model(a2, b2, 4'b0110, er2, ef2);
        apply_stimulus(a1, b1, 4'b0010, ok);
        if (ok) wait_done(lat, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bp_timeout got no out_valid exp out_valid");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_a = a2; bus.in_b = b2; bus.in_op = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_result !== er1 ||
                {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== ef1) begin
                errors++;
                $display("[TB] FAIL bp_hold cyc=%0d got v=%b r=%b res=%h exp v=1 r=0 res=%h", c,
                         bus.out_valid, bus.in_ready, bus.out_result, er1);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== er1) begin
            errors++;
            $display("[TB] FAIL bp_handoff got r=%b v=%b res=%h exp r=1 v=0 res=%h",
                     bus.in_ready, bus.out_valid, bus.out_result, er1);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(lat, ok);
        checks++;
        if (!ok || lat !== W || bus.out_result !== er2 ||
            {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== ef2) begin
            errors++;
            $display("[TB] FAIL b2b_second got lat=%0d res=%h exp lat=%0d res=%h", lat,
                     bus.out_result, W, er2);
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit ok;
        // Leave carry and zero flags set so the reset has something to clear.
        apply_stimulus(8'h05, 8'h05, 4'b0110, ok);
        if (ok) wait_done(lat, ok);
        release_out();
        apply_stimulus(8'h7F, 8'h01, 4'b0010, ok);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== '0 ||
            {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== 4'b0000 ||
            {slice_a, slice_b, slice_cin, slice_op} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid got r=%b v=%b res=%h flags=%b exp r=1 v=0 res=00 flags=0000",
                     bus.in_ready, bus.out_valid, bus.out_result,
                     {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal});
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(8'h12, 8'h34, 4'b0010, ok);
        if (ok) wait_done(lat, ok);
        checks++;
        if (!ok || bus.out_result !== 8'h46) begin
            errors++;
            $display("[TB] FAIL rst_recover got %h exp 46", bus.out_result);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [3:0]   legal_ops[5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};
        logic [W-1:0] a, b, er;
        logic [3:0]   op, ef;
        int           lat;
        bit           ok;
        for (int n = 0; n < 40; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                op = 4'($urandom);
                while (is_legal(op)) op = 4'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 4)];
            end
            ref_model(a, b, op, er, ef);
            apply_stimulus(a, b, op, ok);
            if (ok) wait_done(lat, ok);
            checks++;
            if (!ok || lat !== (is_legal(op) ? W : 0)) begin
                errors++;
                $display("[TB] FAIL rand_latency op=%b got %0d exp %0d", op, lat, is_legal(op) ? W : 0);
            end
            checks++;
            if (bus.out_result !== er ||
                {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal} !== ef) begin
                errors++;
                $display("[TB] FAIL rand_out op=%b a=%h b=%h got res=%h flags=%b exp res=%h flags=%b",
                         op, a, b, bus.out_result,
                         {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal}, er, ef);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
